// File: rtl/lcd_pkg.sv
// Shared constants for the 4-bit character-LCD write path: FSM encoding,
// clear/home detection and default 50 MHz timing.
package lcd_pkg;

  typedef logic [3:0] lcd_state_t;

  localparam lcd_state_t StIdle   = 4'd0;
  localparam lcd_state_t StSetupH = 4'd1;
  localparam lcd_state_t StEH     = 4'd2;
  localparam lcd_state_t StHoldH  = 4'd3;
  localparam lcd_state_t StGap    = 4'd4;
  localparam lcd_state_t StSetupL = 4'd5;
  localparam lcd_state_t StEL     = 4'd6;
  localparam lcd_state_t StHoldL  = 4'd7;
  localparam lcd_state_t StWait   = 4'd8;

  // Commands whose bits [7:2] are all zero (clear 0x01, home 0x02/0x03) need the long wait
  localparam logic [5:0] CLEAR_HOME_MASK = 6'b000000;

  localparam int unsigned DEF_SETUP_CYC      = 2;
  localparam int unsigned DEF_E_HIGH_CYC     = 12;
  localparam int unsigned DEF_HOLD_CYC       = 2;
  localparam int unsigned DEF_NIBBLE_GAP_CYC = 50;
  localparam int unsigned DEF_BYTE_WAIT_CYC  = 2000;
  localparam int unsigned DEF_CLEAR_WAIT_CYC = 82000;

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module lcd_delay_timer
  import lcd_pkg::*;
#(
  parameter int unsigned CNT_W = 17
) (
  input  logic             CCLK,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge CCLK) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// Serialises command/data bytes (or single init nibbles) onto the 4-bit LCD bus
// with setup, E-strobe, hold and controller execution timing.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = DEF_SETUP_CYC,
  parameter int unsigned E_HIGH_CYC     = DEF_E_HIGH_CYC,
  parameter int unsigned HOLD_CYC       = DEF_HOLD_CYC,
  parameter int unsigned NIBBLE_GAP_CYC = DEF_NIBBLE_GAP_CYC,
  parameter int unsigned BYTE_WAIT_CYC  = DEF_BYTE_WAIT_CYC,
  parameter int unsigned CLEAR_WAIT_CYC = DEF_CLEAR_WAIT_CYC,
  parameter int unsigned CNT_W          = $clog2(CLEAR_WAIT_CYC + 1)
) (
  input  logic       CCLK,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  input  logic       in_nibble,
  output logic       busy,
  output logic       LCDE,
  output logic       LCDRS,
  output logic       LCDRW,
  output logic [3:0] LCDDAT
);

  if (SETUP_CYC == 0 || E_HIGH_CYC == 0 || HOLD_CYC == 0 || NIBBLE_GAP_CYC == 0 ||
      BYTE_WAIT_CYC == 0 || CLEAR_WAIT_CYC == 0) begin : gen_bad_timing
    $error("lcd_nibble_writer: all timing parameters must be at least 1");
  end

  lcd_state_t       state_q, state_d;
  logic [7:0]       data_q;
  logic             rs_q;
  logic             nib_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             lcde_q;
  logic             lcdrs_q;
  logic [3:0]       lcddat_q;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_done;
  logic [CNT_W-1:0] wait_load;
  logic             accept;

  assign accept = in_valid && in_ready_q;

  // Nibble-mode init writes never trigger the long clear/home wait
  assign wait_load = (!nib_q && !rs_q && data_q[7:2] == CLEAR_HOME_MASK) ?
                     CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(BYTE_WAIT_CYC - 1);

  lcd_delay_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .CCLK  (CCLK),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StSetupH;
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(SETUP_CYC - 1);
        end
      end
      StSetupH: begin
        if (tmr_done) begin
          state_d   = StEH;
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(E_HIGH_CYC - 1);
        end
      end
      StEH: begin
        if (tmr_done) begin
          state_d   = StHoldH;
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(HOLD_CYC - 1);
        end
      end
      StHoldH: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (nib_q) begin
            state_d   = StWait;
            tmr_value = wait_load;
          end else begin
            state_d   = StGap;
            tmr_value = CNT_W'(NIBBLE_GAP_CYC - 1);
          end
        end
      end
      StGap: begin
        if (tmr_done) begin
          state_d   = StSetupL;
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(SETUP_CYC - 1);
        end
      end
      StSetupL: begin
        if (tmr_done) begin
          state_d   = StEL;
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(E_HIGH_CYC - 1);
        end
      end
      StEL: begin
        if (tmr_done) begin
          state_d   = StHoldL;
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(HOLD_CYC - 1);
        end
      end
      StHoldL: begin
        if (tmr_done) begin
          state_d   = StWait;
          tmr_load  = 1'b1;
          tmr_value = wait_load;
        end
      end
      StWait: begin
        if (tmr_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q
  always_ff @(posedge CCLK) begin
    if (rst) begin
      state_q    <= StIdle;
      data_q     <= '0;
      rs_q       <= 1'b0;
      nib_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      lcde_q     <= 1'b0;
      lcdrs_q    <= 1'b0;
      lcddat_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == StIdle);
      busy_q     <= (state_d != StIdle);
      lcde_q     <= (state_d == StEH) || (state_d == StEL);
      if (accept) begin
        data_q   <= in_data;
        rs_q     <= in_rs;
        nib_q    <= in_nibble;
        lcdrs_q  <= in_rs;
        lcddat_q <= in_nibble ? in_data[3:0] : in_data[7:4];
      end else if (state_q == StGap && state_d == StSetupL) begin
        lcddat_q <= data_q[3:0];
      end
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign LCDE     = lcde_q;
  assign LCDRS    = lcdrs_q;
  assign LCDRW    = 1'b0;
  assign LCDDAT   = lcddat_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer using short timing parameters.
module tb_lcd_nibble_writer;

  logic       CCLK = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_rs = 1'b0;
  logic       in_nibble = 1'b0;
  logic       busy;
  logic       LCDE;
  logic       LCDRS;
  logic       LCDRW;
  logic [3:0] LCDDAT;

  int tests_run = 0;
  int tests_failed = 0;

  lcd_nibble_writer #(
    .SETUP_CYC      (1),
    .E_HIGH_CYC     (2),
    .HOLD_CYC       (1),
    .NIBBLE_GAP_CYC (3),
    .BYTE_WAIT_CYC  (5),
    .CLEAR_WAIT_CYC (20)
  ) dut (
    .CCLK      (CCLK),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_rs     (in_rs),
    .in_nibble (in_nibble),
    .busy      (busy),
    .LCDE      (LCDE),
    .LCDRS     (LCDRS),
    .LCDRW     (LCDRW),
    .LCDDAT    (LCDDAT)
  );

  always #5 CCLK = ~CCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for idle, sends one request, then records the bus until idle again.
  // low_cyc = -1 if the block never became ready.
  task automatic transact(input logic [7:0] d, input logic rs, input logic nib,
                          output int low_cyc, output int npulse, output int ehi,
                          output logic [3:0] dat0, output logic [3:0] dat1,
                          output logic rs_ok, output logic busy_ok);
    int   guard;
    logic prev;
    low_cyc = 0; npulse = 0; ehi = 0; dat0 = 4'hx; dat1 = 4'hx;
    rs_ok = 1'b1; busy_ok = 1'b1; prev = 1'b0; guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge CCLK);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      low_cyc = -1;
      return;
    end
    in_valid = 1'b1; in_data = d; in_rs = rs; in_nibble = nib;
    @(negedge CCLK);
    in_valid = 1'b0;
    while (in_ready !== 1'b1 && low_cyc < 200) begin
      low_cyc++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (LCDRS !== rs) rs_ok = 1'b0;
      if (LCDE === 1'b1) begin
        ehi++;
        if (!prev) begin
          if (npulse == 0) dat0 = LCDDAT;
          else dat1 = LCDDAT;
          npulse++;
        end
      end
      prev = LCDE;
      @(negedge CCLK);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge CCLK);
    tests_run++;
    if (in_ready !== 1'b0 || LCDE !== 1'b0 || LCDDAT !== 4'h0 || busy !== 1'b0 ||
        LCDRS !== 1'b0 || LCDRW !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: ready=%b E=%b DAT=%h busy=%b RS=%b RW=%b, required 0 0 0 0 0 0",
               in_ready, LCDE, LCDDAT, busy, LCDRS, LCDRW);
    end
    rst = 1'b0;
    @(negedge CCLK);
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: ready=%b busy=%b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_data_byte();
    int low, np, eh; logic [3:0] d0, d1; logic rok, bok;
    transact(8'h41, 1'b1, 1'b0, low, np, eh, d0, d1, rok, bok);
    tests_run++;
    if (low !== 16) begin
      tests_failed++; $display("FAIL data_0x41_low: got %0d cycles, required 16", low);
    end
    tests_run++;
    if (np !== 2 || eh !== 4) begin
      tests_failed++;
      $display("FAIL data_0x41_pulses: got %0d pulses / %0d high, required 2 / 4", np, eh);
    end
    tests_run++;
    if (d0 !== 4'h4 || d1 !== 4'h1) begin
      tests_failed++; $display("FAIL data_0x41_nibbles: got %h %h, required 4 1", d0, d1);
    end
    tests_run++;
    if (rok !== 1'b1 || bok !== 1'b1 || LCDRS !== 1'b1 || LCDDAT !== 4'h1) begin
      tests_failed++;
      $display("FAIL data_0x41_rs_busy: rs_ok=%b busy_ok=%b RS=%b DAT=%h, required 1 1 1 1",
               rok, bok, LCDRS, LCDDAT);
    end
    // rs=1 never takes the clear wait even with a 0x01 payload
    transact(8'h01, 1'b1, 1'b0, low, np, eh, d0, d1, rok, bok);
    tests_run++;
    if (low !== 16) begin
      tests_failed++; $display("FAIL data_0x01_low: got %0d cycles, required 16", low);
    end
  endtask

  task automatic test_clear_home();
    int low, np, eh; logic [3:0] d0, d1; logic rok, bok;
    transact(8'h01, 1'b0, 1'b0, low, np, eh, d0, d1, rok, bok);
    tests_run++;
    if (low !== 31) begin
      tests_failed++; $display("FAIL clear_low: got %0d cycles, required 31", low);
    end
    tests_run++;
    if (np !== 2 || d0 !== 4'h0 || d1 !== 4'h1 || rok !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_bus: pulses=%0d nib=%h %h rs_ok=%b, required 2 0 1 1",
               np, d0, d1, rok);
    end
    transact(8'h06, 1'b0, 1'b0, low, np, eh, d0, d1, rok, bok);
    tests_run++;
    if (low !== 16 || d0 !== 4'h0 || d1 !== 4'h6) begin
      tests_failed++;
      $display("FAIL entry_0x06: low=%0d nib=%h %h, required 16 0 6", low, d0, d1);
    end
    transact(8'h03, 1'b0, 1'b0, low, np, eh, d0, d1, rok, bok);
    tests_run++;
    if (low !== 31) begin
      tests_failed++; $display("FAIL home_0x03_low: got %0d cycles, required 31", low);
    end
    transact(8'h04, 1'b0, 1'b0, low, np, eh, d0, d1, rok, bok);
    tests_run++;
    if (low !== 16) begin
      tests_failed++; $display("FAIL cmd_0x04_low: got %0d cycles, required 16", low);
    end
  endtask

  task automatic test_nibble();
    int low, np, eh; logic [3:0] d0, d1; logic rok, bok;
    transact(8'h03, 1'b0, 1'b1, low, np, eh, d0, d1, rok, bok);
    tests_run++;
    if (low !== 9 || np !== 1 || eh !== 2 || d0 !== 4'h3) begin
      tests_failed++;
      $display("FAIL nibble_0x3: low=%0d pulses=%0d high=%0d nib=%h, required 9 1 2 3",
               low, np, eh, d0);
    end
    // Nibble mode with a home-like value still uses the short wait
    transact(8'h02, 1'b0, 1'b1, low, np, eh, d0, d1, rok, bok);
    tests_run++;
    if (low !== 9 || np !== 1 || d0 !== 4'h2) begin
      tests_failed++;
      $display("FAIL nibble_0x2: low=%0d pulses=%0d nib=%h, required 9 1 2", low, np, d0);
    end
  endtask

  task automatic test_back_to_back();
    int low, np, guard; logic [3:0] d0, d1; logic prev;
    low = 0; np = 0; d0 = 4'hx; d1 = 4'hx; prev = 1'b0; guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge CCLK); guard++;
    end
    in_valid = 1'b1; in_data = 8'h41; in_rs = 1'b1; in_nibble = 1'b0;
    @(negedge CCLK);
    while (in_ready !== 1'b1 && low < 200) begin
      low++;
      if (LCDE === 1'b1 && !prev) begin
        if (np == 0) d0 = LCDDAT;
        else d1 = LCDDAT;
        np++;
      end
      prev = LCDE;
      in_data = 8'h90 + 8'(low);
      in_rs = low[0];
      @(negedge CCLK);
    end
    tests_run++;
    if (low !== 16 || np !== 2 || d0 !== 4'h4 || d1 !== 4'h1) begin
      tests_failed++;
      $display("FAIL b2b_first: low=%0d pulses=%0d nib=%h %h, required 16 2 4 1",
               low, np, d0, d1);
    end
    tests_run++;
    if (LCDDAT !== 4'h1 || LCDRS !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_idle_hold: DAT=%h RS=%b, required 1 1", LCDDAT, LCDRS);
    end
    in_data = 8'hA5; in_rs = 1'b0;
    @(negedge CCLK);
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0 || LCDDAT !== 4'hA || LCDRS !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second_accept: ready=%b DAT=%h RS=%b, required 0 a 0",
               in_ready, LCDDAT, LCDRS);
    end
    guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge CCLK); guard++;
    end
    tests_run++;
    if (in_ready !== 1'b1 || LCDDAT !== 4'h5) begin
      tests_failed++;
      $display("FAIL b2b_second_done: ready=%b DAT=%h, required 1 5", in_ready, LCDDAT);
    end
  endtask

  task automatic test_reset_mid();
    int low, np, eh; logic [3:0] d0, d1; logic rok, bok;
    in_valid = 1'b1; in_data = 8'h41; in_rs = 1'b1; in_nibble = 1'b0;
    @(negedge CCLK);
    in_valid = 1'b0;
    @(negedge CCLK);
    tests_run++;
    if (LCDE !== 1'b1 || LCDDAT !== 4'h4) begin
      tests_failed++;
      $display("FAIL mid_pre_reset: E=%b DAT=%h, required 1 4", LCDE, LCDDAT);
    end
    rst = 1'b1;
    @(negedge CCLK);
    tests_run++;
    if (LCDE !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || LCDDAT !== 4'h0 ||
        LCDRS !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: E=%b ready=%b busy=%b DAT=%h RS=%b, required 0 0 0 0 0",
               LCDE, in_ready, busy, LCDDAT, LCDRS);
    end
    rst = 1'b0;
    @(negedge CCLK);
    tests_run++;
    if (in_ready !== 1'b1 || LCDE !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_release: ready=%b E=%b, required 1 0", in_ready, LCDE);
    end
    transact(8'h30, 1'b0, 1'b0, low, np, eh, d0, d1, rok, bok);
    tests_run++;
    if (low !== 16 || np !== 2 || d0 !== 4'h3 || d1 !== 4'h0 || rok !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_after_0x30: low=%0d pulses=%0d nib=%h %h rs_ok=%b, required 16 2 3 0 1",
               low, np, d0, d1, rok);
    end
  endtask

  initial begin
    test_reset();
    test_data_byte();
    test_clear_home();
    test_nibble();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
